// File: rtl/mult_share_ctrl.sv
// Round-robin front end sharing one init/done shift-add multiplier among NREQ requesters.
// Latency req->resp_valid is 3 + multiplier latency; requesters wait (hold req) until their resp_valid.
module mult_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int W       = 3,
    parameter int TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   md_in,
    input  logic [NREQ*W-1:0]   mr_in,
    output logic [NREQ-1:0]     resp_valid,
    output logic [2*W-1:0]      resp_data,
    output logic                resp_err,
    output logic                busy,
    output logic                mul_rst,
    output logic                mul_init,
    output logic [W-1:0]        mul_md,
    output logic [W-1:0]        mul_mr,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_pp
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ABORT
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      idx_q;
    logic [TW-1:0]      timer_q;
    logic [NREQ-1:0]    resp_valid_q;
    logic [2*W-1:0]     resp_data_q;
    logic               resp_err_q;
    logic               busy_q;
    logic               mul_rst_q;
    logic               mul_init_q;
    logic [W-1:0]       mul_md_q;
    logic [W-1:0]       mul_mr_q;

    logic               pick_vld_d;
    logic [IW-1:0]      pick_idx_d;
    logic [IW-1:0]      ptr_d;
    logic [NREQ-1:0]    onehot_d;

    // Scan from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % NREQ]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign ptr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
    assign onehot_d = NREQ'(1) << idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            mul_rst_q    <= 1'b0;
            mul_init_q   <= 1'b0;
            mul_md_q     <= '0;
            mul_mr_q     <= '0;
        end else begin
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            mul_rst_q    <= 1'b0;
            mul_init_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        idx_q      <= pick_idx_d;
                        mul_md_q   <= md_in[int'(pick_idx_d) * W +: W];
                        mul_mr_q   <= mr_in[int'(pick_idx_d) * W +: W];
                        mul_init_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                // done may still be high from the previous op here; it is not looked at.
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        resp_data_q  <= mul_pp;
                        resp_valid_q <= onehot_d;
                        state_q      <= S_RESP;
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        mul_rst_q    <= 1'b1;
                        resp_valid_q <= onehot_d;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                        state_q      <= S_ABORT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RESP, S_ABORT: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign mul_rst    = mul_rst_q;
    assign mul_init   = mul_init_q;
    assign mul_md     = mul_md_q;
    assign mul_mr     = mul_mr_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: behavioural multiplier with random latency plus a round-robin scoreboard.
module tb_mult_share_ctrl;

    localparam int NREQ    = 4;
    localparam int W       = 3;
    localparam int TIMEOUT = 31;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   md_in;
    logic [NREQ*W-1:0]   mr_in;
    logic [NREQ-1:0]     resp_valid;
    logic [2*W-1:0]      resp_data;
    logic                resp_err;
    logic                busy;
    logic                mul_rst;
    logic                mul_init;
    logic [W-1:0]        mul_md;
    logic [W-1:0]        mul_mr;
    logic                mul_done;
    logic [2*W-1:0]      mul_pp;

    mult_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .md_in      (md_in),
        .mr_in      (mr_in),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .mul_rst    (mul_rst),
        .mul_init   (mul_init),
        .mul_md     (mul_md),
        .mul_mr     (mul_mr),
        .mul_done   (mul_done),
        .mul_pp     (mul_pp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural multiplier: done level held until next init, latency 8..11, optional hang.
    bit              op_stuck;
    bit              m_stuck;
    bit              m_act;
    int              m_cnt;
    int              m_l;
    int              last_lat;
    logic [W-1:0]    m_a, m_b;

    always @(posedge clk) begin
        if (rst || mul_rst) begin
            mul_done <= 1'b0;
            m_act    <= 1'b0;
            m_cnt    <= 0;
        end else if (mul_init) begin
            m_l       = $urandom_range(11, 8);
            last_lat <= m_l;
            m_cnt    <= m_l;
            m_act    <= 1'b1;
            mul_done <= 1'b0;
            m_a      <= mul_md;
            m_b      <= mul_mr;
            m_stuck  <= op_stuck;
        end else if (m_act) begin
            if (m_cnt == 1) begin
                m_act <= 1'b0;
                if (!m_stuck) begin
                    mul_done <= 1'b1;
                    mul_pp   <= {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Scoreboard state: mstate 0 = idle, 1 = op granted, 2 = response just seen
    int          mstate;
    int          ptr_m;
    int          e_idx, e_prod, g_cyc, cyc;
    bit          e_err;
    bit          force_stuck;
    int          init_cnt, rst_cnt;
    int          hold_off [NREQ];
    logic [W-1:0] dmd [NREQ];
    logic [W-1:0] dmr [NREQ];
    int          served [$];

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic step(input logic [NREQ-1:0] raise, input bit rand_ops);
        @(negedge clk);
        cyc++;
        if (mstate == 2) mstate = 0;
        if (mul_init) init_cnt++;
        if (mul_rst)  rst_cnt++;
        check("busy", 32'(busy), 32'(mstate != 0));
        if (resp_valid != '0) begin
            if (mstate != 1) begin
                check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                check("resp_valid", 32'(resp_valid), 32'(1) << e_idx);
                check("resp_err", 32'(resp_err), 32'(e_err));
                check("resp_data", 32'(resp_data), e_err ? 32'd0 : 32'(e_prod));
                check("mul_init_pulses", 32'(init_cnt), 32'd1);
                check("mul_rst_pulses", 32'(rst_cnt), 32'(e_err));
                if (e_err)
                    check("abort_latency", 32'((cyc - g_cyc >= TIMEOUT + 2) && (cyc - g_cyc <= TIMEOUT + 3)), 32'd1);
                else
                    check("latency", 32'(cyc - g_cyc), 32'(last_lat + 3));
                served.push_back(e_idx);
                req[e_idx]      = 1'b0;
                hold_off[e_idx] = 2;
                ptr_m           = (e_idx + 1) % NREQ;
            end
            mstate = 2;
        end else if (mstate == 1 && (cyc - g_cyc) > TIMEOUT + 10) begin
            check("resp_timeout", 32'd0, 32'd1);
            mstate = 0;
            req    = '0;
        end
        // Operand changes after grant must not disturb the op in flight.
        if (rand_ops && mstate == 1 && $urandom_range(3, 0) == 0) begin
            md_in[e_idx*W +: W] = W'($urandom);
            mr_in[e_idx*W +: W] = W'($urandom);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (raise[i] && !req[i] && hold_off[i] == 0) begin
                req[i] = 1'b1;
                md_in[i*W +: W] = rand_ops ? W'($urandom) : dmd[i];
                mr_in[i*W +: W] = rand_ops ? W'($urandom) : dmr[i];
            end
            if (hold_off[i] > 0) hold_off[i]--;
        end
        if (mstate == 0 && req != '0) begin
            e_idx    = rr_pick(req, ptr_m);
            e_prod   = int'(md_in[e_idx*W +: W]) * int'(mr_in[e_idx*W +: W]);
            op_stuck = force_stuck || (rand_ops && $urandom_range(7, 0) == 0);
            e_err    = op_stuck;
            g_cyc    = cyc;
            init_cnt = 0;
            rst_cnt  = 0;
            mstate   = 1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mstate != 0 || req != '0) && n < 200) begin
            step('0, 1'b0);
            n++;
        end
        check("drain_done", 32'(mstate == 0 && req == '0), 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        req   = '0;
        md_in = '0;
        mr_in = '0;
        repeat (n) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mul_rst", 32'(mul_rst), 32'd0);
        check("rst_mul_init", 32'(mul_init), 32'd0);
        check("rst_mul_opnds", 32'({mul_md, mul_mr}), 32'd0);
        mstate = 0;
        ptr_m  = 0;
        for (int i = 0; i < NREQ; i++) hold_off[i] = 0;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; req = '0; md_in = '0; mr_in = '0;
        op_stuck = 1'b0; force_stuck = 1'b0; cyc = 0;
        for (int i = 0; i < NREQ; i++) begin dmd[i] = '0; dmr[i] = '0; end
        do_reset(3);

        // Single op and exact product.
        dmd[0] = 3'd3; dmr[0] = 3'd5;
        step(4'b0001, 1'b0); drain();
        check("t1_data", 32'(resp_data), 32'd15);

        // Back-to-back ops on one requester; second result must not be the stale first one.
        dmd[2] = 3'd7; dmr[2] = 3'd7;
        step(4'b0100, 1'b0); drain();
        check("t2_data_a", 32'(resp_data), 32'd49);
        dmd[2] = 3'd0; dmr[2] = 3'd6;
        step(4'b0100, 1'b0); drain();
        check("t2_data_b", 32'(resp_data), 32'd0);

        // Fairness with all requests held.
        do_reset(1);
        for (int i = 0; i < NREQ; i++) begin dmd[i] = W'(i + 1); dmr[i] = 3'd2; end
        served.delete();
        n = 0;
        while (served.size() < 5 && n < 400) begin step(4'b1111, 1'b0); n++; end
        check("t3_count", 32'(served.size()), 32'd5);
        if (served.size() >= 5) begin
            check("t3_order0", 32'(served[0]), 32'd0);
            check("t3_order1", 32'(served[1]), 32'd1);
            check("t3_order2", 32'(served[2]), 32'd2);
            check("t3_order3", 32'(served[3]), 32'd3);
            check("t3_order4", 32'(served[4]), 32'd0);
        end
        drain();

        // Hung multiplier, then a normal op.
        force_stuck = 1'b1;
        dmd[1] = 3'd2; dmr[1] = 3'd3;
        step(4'b0010, 1'b0); drain();
        force_stuck = 1'b0;
        dmd[1] = 3'd6; dmr[1] = 3'd7;
        step(4'b0010, 1'b0); drain();
        check("t4_recover", 32'(resp_data), 32'd42);

        // Reset in WAIT: ptr returns to 0 so {1,3} picks 1.
        do_reset(1);
        dmd[1] = 3'd1; dmr[1] = 3'd1;
        step(4'b0010, 1'b0); drain();
        dmd[2] = 3'd5; dmr[2] = 3'd5;
        step(4'b0100, 1'b0);
        repeat (5) step('0, 1'b0);
        do_reset(1);
        dmd[1] = 3'd3; dmr[1] = 3'd4;
        dmd[3] = 3'd2; dmr[3] = 3'd2;
        served.delete();
        step(4'b1010, 1'b0); drain();
        check("t5_first", 32'(served.size() > 0 ? served[0] : -1), 32'd1);
        check("t5_data", 32'(resp_data), 32'd4);

        // Random traffic.
        for (int k = 0; k < 600; k++)
            step(NREQ'($urandom & $urandom), 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
